// File: rtl/aes_pkg.sv
// Shared AES definitions: forward S-box, schedule constants, FSM state type
// and the backward rcon step used by the inverse key schedule.
package aes_pkg;

  localparam logic [3:0] NR        = 4'd10;
  localparam logic [7:0] RCON_LAST = 8'h36;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX_TABLE[a];
  endfunction

  // Undo one GF(2^8) doubling: odd values had the 0x1b reduction applied.
  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return r[0] ? (((r ^ 8'h1b) >> 1) | 8'h80) : (r >> 1);
  endfunction

endpackage

// File: rtl/aes_inv_key_scheduling_if.sv
// Key-request / key-stream bundle between the inverse key schedule and its user.
// Handshake: a key transfers on any rising edge where key_valid_o & key_ready_i.
interface aes_inv_key_scheduling_if;
  import aes_pkg::*;

  logic         start_i;
  logic [127:0] key_i;
  logic         ready_o;
  logic         key_valid_o;
  logic         key_ready_i;
  logic [127:0] key_o;
  logic [3:0]   round_o;
  logic [7:0]   key_rcon_o;
  logic         last_o;
  state_t       state;

  modport master (
    output start_i, key_i, key_ready_i,
    input  ready_o, key_valid_o, key_o, round_o, key_rcon_o, last_o, state
  );

  modport slave (
    input  start_i, key_i, key_ready_i,
    output ready_o, key_valid_o, key_o, round_o, key_rcon_o, last_o, state
  );

endinterface

// File: rtl/aes_inv_key_round.sv
// One backward step of the AES-128 key schedule: K[r] -> K[r-1], and the rcon
// that K[r-1] will need to undo its own expansion.
module aes_inv_key_round
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   key_rcon_i,
  output logic [127:0] key_prev_o,
  output logic [7:0]   key_rcon_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic [31:0] rot, t;

  assign {w0, w1, w2, w3} = key_i;

  assign n3 = w3 ^ w2;
  assign n2 = w2 ^ w1;
  assign n1 = w1 ^ w0;

  // The forward step derived t from the previous w3, which is n3 here.
  assign rot = {n3[23:0], n3[31:24]};
  assign t   = {sbox(rot[31:24]) ^ key_rcon_i, sbox(rot[23:16]),
                sbox(rot[15:8]), sbox(rot[7:0])};
  assign n0  = w0 ^ t;

  assign key_prev_o = {n0, n1, n2, n3};
  assign key_rcon_o = inv_xtime(key_rcon_i);

endmodule

// File: rtl/aes_inv_key_scheduling.sv
// AES-128 inverse key schedule: loads K[10] and streams K[10]..K[0], one round
// key per accepted transfer.
module aes_inv_key_scheduling
  import aes_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset,
  aes_inv_key_scheduling_if.slave        bus
);

  state_t       state_q, state_d;
  logic [127:0] key_q;
  logic [7:0]   rcon_q;
  logic [3:0]   round_q;
  logic [127:0] key_prev;
  logic [7:0]   rcon_prev;
  logic         load, step;

  aes_inv_key_round u_round (
    .key_i      (key_q),
    .key_rcon_i (rcon_q),
    .key_prev_o (key_prev),
    .key_rcon_o (rcon_prev)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.key_ready_i) begin
          // After K[0] is taken the registers hold; only the state returns.
          if (round_q != 4'd0) step = 1'b1;
          else                 state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      key_q   <= '0;
      rcon_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        key_q   <= bus.key_i;
        rcon_q  <= RCON_LAST;
        round_q <= NR;
      end else if (step) begin
        key_q   <= key_prev;
        rcon_q  <= rcon_prev;
        round_q <= round_q - 4'd1;
      end
    end
  end

  assign bus.ready_o     = (state_q == IDLE);
  assign bus.key_valid_o = (state_q == RUN);
  assign bus.key_o       = key_q;
  assign bus.round_o     = round_q;
  assign bus.key_rcon_o  = rcon_q;
  assign bus.last_o      = (state_q == RUN) && (round_q == 4'd0);
  assign bus.state       = state_q;

endmodule
